// File: rtl/spi_frame_pkg.sv
// -----------------------------------------------------------------------------
// spi_frame_pkg
// Shared constants for the SPI robot-control frame slave: command codes,
// payload lengths, PWM limits, FSM state encodings, LED register indices and
// the PWM clamp helper.
// -----------------------------------------------------------------------------
package spi_frame_pkg;

   localparam logic [7:0] CMD_MOTOR = 8'h01;
   localparam logic [7:0] CMD_LED   = 8'h02;

   // Address and command bytes precede every payload.
   localparam logic [2:0] HDR_LEN   = 3'd2;
   localparam logic [2:0] LEN_MOTOR = 3'd2;
   localparam logic [2:0] LEN_LED   = 3'd4;

   localparam logic signed [7:0] PWM_MAX = 8'sd100;
   localparam logic signed [7:0] PWM_MIN = -8'sd100;

   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_ADDR    = 3'd1;
   localparam state_t ST_CMD     = 3'd2;
   localparam state_t ST_PAYLOAD = 3'd3;
   localparam state_t ST_IGNORE  = 3'd4;

   localparam logic [1:0] LED_EYE_LEFT   = 2'd0;
   localparam logic [1:0] LED_EYE_RGHT   = 2'd1;
   localparam logic [1:0] LED_BLINK_LEFT = 2'd2;
   localparam logic [1:0] LED_BLINK_RGHT = 2'd3;

   // Limit a signed PWM request to -100..100 (8'h80 lands on -100).
   function automatic logic signed [7:0] clamp_pwm(input logic signed [7:0] v);
      if (v > PWM_MAX)
         clamp_pwm = PWM_MAX;
      else if (v < PWM_MIN)
         clamp_pwm = PWM_MIN;
      else
         clamp_pwm = v;
   endfunction

endpackage

// File: rtl/spi_slave_byte.sv
// -----------------------------------------------------------------------------
// spi_slave_byte
// Mode-0 SPI byte engine running in the system clock domain.
// Ports:
//   clk, rst            system clock, async active-high reset
//   sclk_i, mosi_i,     raw asynchronous SPI pins
//   spi_ss_n_i
//   tx_byte             byte to load: sampled on ss_fall (first byte out) and
//                       on byte_valid (byte for the next slot)
//   byte_valid          1-cycle pulse when the 8th bit of a byte is shifted in
//   rx_byte             completed byte, valid with byte_valid
//   ss_fall, ss_rise    1-cycle slave-select edge pulses
//   partial             bit counter is mid-byte
//   sel                 synchronized slave select (active high)
//   miso_bit            current MISO bit, 0 while deselected
// -----------------------------------------------------------------------------
module spi_slave_byte (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk_i,
   input  logic       mosi_i,
   input  logic       spi_ss_n_i,
   input  logic [7:0] tx_byte,
   output logic       byte_valid,
   output logic [7:0] rx_byte,
   output logic       ss_fall,
   output logic       ss_rise,
   output logic       partial,
   output logic       sel,
   output logic       miso_bit
);

   logic       sclk_meta_q, sclk_meta_d, sclk_sync_q, sclk_sync_d, sclk_prev_q, sclk_prev_d;
   logic       ss_meta_q, ss_meta_d, ss_sync_q, ss_sync_d, ss_prev_q, ss_prev_d;
   logic       mosi_meta_q, mosi_meta_d, mosi_sync_q, mosi_sync_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] rx_shift_q, rx_shift_d;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic [7:0] tx_next_q, tx_next_d;
   logic       sclk_rise, sclk_fall;

   always_comb begin
      sclk_meta_d = sclk_i;
      sclk_sync_d = sclk_meta_q;
      sclk_prev_d = sclk_sync_q;
      ss_meta_d   = spi_ss_n_i;
      ss_sync_d   = ss_meta_q;
      ss_prev_d   = ss_sync_q;
      mosi_meta_d = mosi_i;
      mosi_sync_d = mosi_meta_q;

      sclk_rise = sclk_sync_q & ~sclk_prev_q;
      sclk_fall = ~sclk_sync_q & sclk_prev_q;
      ss_fall   = ~ss_sync_q & ss_prev_q;
      ss_rise   = ss_sync_q & ~ss_prev_q;
      sel       = ~ss_sync_q;
      partial   = (bit_cnt_q != 3'd0);
      miso_bit  = sel & tx_shift_q[7];

      // MOSI has the same synchronizer depth as SCLK, so it is aligned here.
      rx_byte    = {rx_shift_q[6:0], mosi_sync_q};
      byte_valid = sclk_rise & sel & (bit_cnt_q == 3'd7);

      bit_cnt_d  = bit_cnt_q;
      rx_shift_d = rx_shift_q;
      tx_shift_d = tx_shift_q;
      tx_next_d  = tx_next_q;

      if (ss_fall || ss_rise) begin
         bit_cnt_d = 3'd0;
      end else if (sclk_rise && sel) begin
         rx_shift_d = rx_byte;
         bit_cnt_d  = bit_cnt_q + 3'd1;
      end

      // A falling edge with the bit counter back at 0 follows the 8th rising
      // edge: that is where the next byte's MSB must appear.
      if (ss_fall)
         tx_shift_d = tx_byte;
      else if (sclk_fall && sel)
         tx_shift_d = (bit_cnt_q == 3'd0) ? tx_next_q : {tx_shift_q[6:0], 1'b0};

      if (byte_valid)
         tx_next_d = tx_byte;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_meta_q <= 1'b0;
         sclk_sync_q <= 1'b0;
         sclk_prev_q <= 1'b0;
         ss_meta_q   <= 1'b1;
         ss_sync_q   <= 1'b1;
         ss_prev_q   <= 1'b1;
         mosi_meta_q <= 1'b0;
         mosi_sync_q <= 1'b0;
         bit_cnt_q   <= 3'd0;
         rx_shift_q  <= 8'h00;
         tx_shift_q  <= 8'h00;
         tx_next_q   <= 8'h00;
      end else begin
         sclk_meta_q <= sclk_meta_d;
         sclk_sync_q <= sclk_sync_d;
         sclk_prev_q <= sclk_prev_d;
         ss_meta_q   <= ss_meta_d;
         ss_sync_q   <= ss_sync_d;
         ss_prev_q   <= ss_prev_d;
         mosi_meta_q <= mosi_meta_d;
         mosi_sync_q <= mosi_sync_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         tx_next_q   <= tx_next_d;
      end
   end

endmodule

// File: rtl/spi_frame_slave.sv
// -----------------------------------------------------------------------------
// spi_frame_slave
// SPI mode-0 slave decoding addressed MOTOR / LED command frames. Registers
// update atomically when slave select rises after a well-formed frame; a
// watchdog zeroes the motor outputs if MOTOR frames stop arriving.
// Ports:
//   clk, rst                      system clock, async active-high reset
//   sclk_i, mosi_i, spi_ss_n_i    SPI pins from the master (asynchronous)
//   miso_o, miso_en_o             SPI data out and its drive enable
//   rpi_running_i                 master alive; 0 forces motor outputs to 0
//   motor_pwm_left_o/_rght_o      signed PWM, -100..100
//   led_*_rgb_o                   RGB registers, R[23:16] G[15:8] B[7:0]
//   frame_ok_o, frame_err_o       1-cycle accept / reject pulses
//   wdt_trip_o                    watchdog expired (level)
// -----------------------------------------------------------------------------
module spi_frame_slave
   import spi_frame_pkg::*;
#(
   parameter logic [7:0] DEV_ADDR   = 8'h08,
   parameter int         WDT_CYCLES = 12_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sclk_i,
   input  logic        mosi_i,
   input  logic        spi_ss_n_i,
   output logic        miso_o,
   output logic        miso_en_o,
   input  logic        rpi_running_i,
   output logic [7:0]  motor_pwm_left_o,
   output logic [7:0]  motor_pwm_rght_o,
   output logic [23:0] led_eye_left_rgb_o,
   output logic [23:0] led_eye_rght_rgb_o,
   output logic [23:0] led_blink_left_rgb_o,
   output logic [23:0] led_blink_rght_rgb_o,
   output logic        frame_ok_o,
   output logic        frame_err_o,
   output logic        wdt_trip_o
);

   localparam int              WDT_W   = $clog2(WDT_CYCLES + 1);
   localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_CYCLES);

   logic        byte_valid, ss_fall, ss_rise, partial, sel, miso_bit;
   logic [7:0]  rx_byte, tx_byte;

   state_t              state_q, state_d;
   logic [2:0]          byte_cnt_q, byte_cnt_d;
   logic [7:0]          fbuf_q [8];
   logic [7:0]          fbuf_d [8];
   logic [7:0]          ok_cnt_q, ok_cnt_d;
   logic signed [7:0]   pwm_left_q, pwm_left_d, pwm_rght_q, pwm_rght_d;
   logic [23:0]         led_q [4];
   logic [23:0]         led_d [4];
   logic                frame_ok_q, frame_ok_d, frame_err_q, frame_err_d;
   logic [WDT_W-1:0]    wdt_cnt_q, wdt_cnt_d;
   logic                is_motor, exact_len, idx_ok, motor_commit, motor_on;

   // tx_byte doubles as the first byte of a frame (accepted-frame count,
   // taken on ss_fall) and as the echo of the byte just received.
   assign tx_byte = byte_valid ? rx_byte : ok_cnt_q;

   spi_slave_byte u_byte (
      .clk        (clk),
      .rst        (rst),
      .sclk_i     (sclk_i),
      .mosi_i     (mosi_i),
      .spi_ss_n_i (spi_ss_n_i),
      .tx_byte    (tx_byte),
      .byte_valid (byte_valid),
      .rx_byte    (rx_byte),
      .ss_fall    (ss_fall),
      .ss_rise    (ss_rise),
      .partial    (partial),
      .sel        (sel),
      .miso_bit   (miso_bit)
   );

   always_comb begin
      state_d      = state_q;
      byte_cnt_d   = byte_cnt_q;
      fbuf_d       = fbuf_q;
      ok_cnt_d     = ok_cnt_q;
      pwm_left_d   = pwm_left_q;
      pwm_rght_d   = pwm_rght_q;
      led_d        = led_q;
      frame_ok_d   = 1'b0;
      frame_err_d  = 1'b0;
      motor_commit = 1'b0;

      // byte_cnt counts header bytes too, so lengths are offset by HDR_LEN.
      is_motor  = (fbuf_q[1] == CMD_MOTOR);
      exact_len = is_motor ? (byte_cnt_q == HDR_LEN + LEN_MOTOR)
                           : (byte_cnt_q == HDR_LEN + LEN_LED);
      idx_ok    = is_motor || (fbuf_q[2] <= 8'd3);

      if (ss_rise) begin
         state_d = ST_IDLE;
         if (state_q == ST_PAYLOAD && !partial && exact_len && idx_ok) begin
            frame_ok_d = 1'b1;
            ok_cnt_d   = ok_cnt_q + 8'd1;
            if (is_motor) begin
               pwm_left_d   = clamp_pwm(signed'(fbuf_q[2]));
               pwm_rght_d   = clamp_pwm(signed'(fbuf_q[3]));
               motor_commit = 1'b1;
            end else begin
               led_d[fbuf_q[2][1:0]] = {fbuf_q[3], fbuf_q[4], fbuf_q[5]};
            end
         end else if (state_q == ST_PAYLOAD || state_q == ST_CMD) begin
            frame_err_d = 1'b1;
         end
      end else if (ss_fall) begin
         state_d    = ST_ADDR;
         byte_cnt_d = 3'd0;
      end else if (byte_valid) begin
         fbuf_d[byte_cnt_q] = rx_byte;
         if (byte_cnt_q != 3'd7)
            byte_cnt_d = byte_cnt_q + 3'd1;
         case (state_q)
            ST_ADDR: state_d = (rx_byte == DEV_ADDR) ? ST_CMD : ST_IGNORE;
            ST_CMD:  state_d = (rx_byte == CMD_MOTOR || rx_byte == CMD_LED) ? ST_PAYLOAD : ST_IGNORE;
            default: state_d = state_q;
         endcase
      end

      // Clearing on commit also covers a commit landing on the expiry cycle.
      if (motor_commit)
         wdt_cnt_d = '0;
      else if (wdt_cnt_q == WDT_MAX)
         wdt_cnt_d = wdt_cnt_q;
      else
         wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         byte_cnt_q  <= 3'd0;
         for (int i = 0; i < 8; i++) fbuf_q[i] <= 8'h00;
         ok_cnt_q    <= 8'h00;
         pwm_left_q  <= 8'sd0;
         pwm_rght_q  <= 8'sd0;
         for (int i = 0; i < 4; i++) led_q[i] <= 24'h0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         wdt_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         fbuf_q      <= fbuf_d;
         ok_cnt_q    <= ok_cnt_d;
         pwm_left_q  <= pwm_left_d;
         pwm_rght_q  <= pwm_rght_d;
         led_q       <= led_d;
         frame_ok_q  <= frame_ok_d;
         frame_err_q <= frame_err_d;
         wdt_cnt_q   <= wdt_cnt_d;
      end
   end

   // Stored PWM values survive masking; only the outputs are forced to 0.
   assign wdt_trip_o       = (wdt_cnt_q == WDT_MAX);
   assign motor_on         = rpi_running_i & ~wdt_trip_o;
   assign motor_pwm_left_o = motor_on ? $unsigned(pwm_left_q) : 8'h00;
   assign motor_pwm_rght_o = motor_on ? $unsigned(pwm_rght_q) : 8'h00;

   assign led_eye_left_rgb_o   = led_q[LED_EYE_LEFT];
   assign led_eye_rght_rgb_o   = led_q[LED_EYE_RGHT];
   assign led_blink_left_rgb_o = led_q[LED_BLINK_LEFT];
   assign led_blink_rght_rgb_o = led_q[LED_BLINK_RGHT];

   assign frame_ok_o  = frame_ok_q;
   assign frame_err_o = frame_err_q;
   assign miso_o      = miso_bit;
   assign miso_en_o   = sel;

endmodule
